// File: rtl/ddr_req_sched_if.sv
// ddr_req_sched_if
// Purpose : bundles the requester-side handshake and the DDR command/response
//           bus of the DDR request scheduler into one interface.
// Signals : req_valid/req_ready/req_index/req_write/req_wdata   - 3 requesters
//           resp_done/resp_rdata/resp_err                       - completion
//           ddr_chip_enable/ddr_write_enable/ddr_burst_mode,
//           ddr_index/ddr_write_data                            - DDR command
//           ddr_read_data/ddr_operation_done/ddr_ready          - DDR status
// Modports: slave  - the scheduler itself
//           master - the environment (requesters + DDR model)
interface ddr_req_sched_if;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0][63:0]  req_index;
  logic [2:0]        req_write;
  logic [2:0][511:0] req_wdata;
  logic [2:0]        resp_done;
  logic [511:0]      resp_rdata;
  logic              resp_err;
  logic              ddr_chip_enable;
  logic              ddr_write_enable;
  logic              ddr_burst_mode;
  logic [63:0]       ddr_index;
  logic [511:0]      ddr_write_data;
  logic [511:0]      ddr_read_data;
  logic              ddr_operation_done;
  logic              ddr_ready;

  modport slave (
    input  req_valid, req_index, req_write, req_wdata,
    input  ddr_read_data, ddr_operation_done, ddr_ready,
    output req_ready, resp_done, resp_rdata, resp_err,
    output ddr_chip_enable, ddr_write_enable, ddr_burst_mode,
    output ddr_index, ddr_write_data
  );

  modport master (
    output req_valid, req_index, req_write, req_wdata,
    output ddr_read_data, ddr_operation_done, ddr_ready,
    input  req_ready, resp_done, resp_rdata, resp_err,
    input  ddr_chip_enable, ddr_write_enable, ddr_burst_mode,
    input  ddr_index, ddr_write_data
  );
endinterface

// File: rtl/ddr_req_sched.sv
// ddr_req_sched
// Purpose : round-robin scheduler putting three requesters (0 icache,
//           1 dcache, 2 ptw) onto a single DDR port, one operation at a time.
//           FSM IDLE -> ISSUE (one chip_enable cycle) -> WAIT (until done).
// Ports   : clock, reset     - single clock, synchronous active-high reset
//           bus (slave)      - requester handshake + DDR command/response
//           busy             - FSM not in IDLE
//           grant_id         - id of the current or last grant
// Params  : TIMEOUT_CYCLES   - WAIT watchdog limit (timeout build only)
//           PTW_BURST        - ddr_burst_mode value for requester 2
// Config  : define DDR_REQ_SCHED_TIMEOUT_EN to enable the WAIT watchdog;
//           without it resp_err is tied low and WAIT never times out.
module ddr_req_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          PTW_BURST      = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  ddr_req_sched_if.slave  bus,
  output logic            busy,
  output logic [1:0]      grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t       state_reg;
  logic [1:0]   ptr_reg;
  logic [1:0]   gid_reg;
  logic [63:0]  index_reg;
  logic [511:0] wdata_reg;
  logic [511:0] rdata_reg;
  logic         burst_reg;
  logic         ce_reg;
  logic         we_reg;
  logic [2:0]   done_reg;

`ifdef DDR_REQ_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            err_reg;
`endif

  // Search order ptr+1, ptr+2, ptr (mod 3); ptr is always 0..2.
  logic [1:0] cand [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum       = {1'b0, ptr_reg} + 3'(gi + 1);
    assign cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  logic [1:0] grant_sel;
  logic       grant_fire;
  logic [2:0] wr_eff;

  always_comb begin
    grant_sel = cand[2];
    if (bus.req_valid[cand[1]]) grant_sel = cand[1];
    if (bus.req_valid[cand[0]]) grant_sel = cand[0];
  end

  assign grant_fire = (state_reg == S_IDLE) && bus.ddr_ready && (|bus.req_valid);
  // The icache never writes: its write flag is masked off.
  assign wr_eff     = bus.req_write & 3'b110;

  assign bus.req_ready        = grant_fire ? (3'b001 << grant_sel) : 3'b000;
  assign bus.resp_done        = done_reg;
  assign bus.resp_rdata       = rdata_reg;
  assign bus.ddr_chip_enable  = ce_reg;
  assign bus.ddr_write_enable = we_reg;
  assign bus.ddr_burst_mode   = burst_reg;
  assign bus.ddr_index        = index_reg;
  assign bus.ddr_write_data   = wdata_reg;
  assign busy                 = (state_reg != S_IDLE);
  assign grant_id             = gid_reg;

`ifdef DDR_REQ_SCHED_TIMEOUT_EN
  assign bus.resp_err = err_reg;
`else
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= 2'd2;
      gid_reg   <= 2'd0;
      index_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      burst_reg <= 1'b0;
      ce_reg    <= 1'b0;
      we_reg    <= 1'b0;
      done_reg  <= 3'b000;
`ifdef DDR_REQ_SCHED_TIMEOUT_EN
      wd_reg    <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      // Strobes and the completion pulse are single-cycle by default.
      ce_reg   <= 1'b0;
      we_reg   <= 1'b0;
      done_reg <= 3'b000;
`ifdef DDR_REQ_SCHED_TIMEOUT_EN
      err_reg  <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (grant_fire) begin
            ptr_reg   <= grant_sel;
            gid_reg   <= grant_sel;
            index_reg <= bus.req_index[grant_sel];
            wdata_reg <= bus.req_wdata[grant_sel];
            burst_reg <= (grant_sel == 2'd2) ? PTW_BURST : 1'b1;
            // Command strobes are registered here so they are high exactly
            // during the ISSUE cycle.
            ce_reg    <= 1'b1;
            we_reg    <= wr_eff[grant_sel];
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef DDR_REQ_SCHED_TIMEOUT_EN
          wd_reg    <= '0;
`endif
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ddr_operation_done) begin
            rdata_reg <= bus.ddr_read_data;
            done_reg  <= 3'b001 << gid_reg;
            state_reg <= S_IDLE;
          end
`ifdef DDR_REQ_SCHED_TIMEOUT_EN
          else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_reg <= '0;
            done_reg  <= 3'b001 << gid_reg;
            err_reg   <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_req_sched.sv
// tb_ddr_req_sched
// Purpose : self-checking bench for ddr_req_sched. Expected completions are
//           queued at grant time and compared by a monitor when resp_done
//           pulses; timing and command-bus values are checked inline.
module tb_ddr_req_sched;

  localparam bit PTW_B = 1'b0;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;

  ddr_req_sched_if bus ();

  ddr_req_sched #(
    .TIMEOUT_CYCLES(16),
    .PTW_BURST     (PTW_B)
  ) dut (
    .clock   (clk),
    .reset   (rst),
    .bus     (bus),
    .busy    (busy),
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           id;
    bit           rd;
    logic [511:0] data;
    bit           err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic make_data(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
  endtask

  // Completion scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.resp_done != 3'b000) begin
      if (sb.size() == 0) begin
        check("sb_spurious", 512'(bus.resp_done), 512'(3'b000));
      end else begin
        mon_e = sb.pop_front();
        check("sb_id", 512'(bus.resp_done), 512'(3'b001 << mon_e.id));
        check("sb_err", 512'(bus.resp_err), 512'(mon_e.err));
        if (mon_e.rd) check("sb_rdata", bus.resp_rdata, mon_e.data);
        $display("resp: id=%0d err=%0b", mon_e.id, bus.resp_err);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Entered a little after a negedge; leaves 1 ns after the negedge of the
  // resp_done cycle. done is asserted lat cycles after the chip_enable cycle.
  task automatic run_txn(input logic [2:0] valid, input logic [2:0] wr, input bit hold,
                         input int exp_g, input int lat, input logic [511:0] data);
    int         waited;
    logic [2:0] exp_oh;
    bit         exp_we;
    exp_t       it;
    exp_oh = 3'b001 << exp_g;
    exp_we = (exp_g != 0) && wr[exp_g];
    bus.req_valid = valid;
    bus.req_write = wr;
    #1;
    waited = 0;
    while (bus.req_ready == 3'b000 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("grant_lat", 512'(waited), 512'(0));
    check("grant", 512'(bus.req_ready), 512'(exp_oh));
    it.id = exp_g; it.rd = !exp_we; it.data = data; it.err = 1'b0;
    sb.push_back(it);
    $display("txn: valid=%b write=%b grant=%b", valid, wr, bus.req_ready);
    @(negedge clk);  // ISSUE cycle
    if (!hold) bus.req_valid = 3'b000;
    bus.ddr_operation_done = 1'b1;  // must be ignored outside WAIT
    #1;
    check("ce_issue", 512'(bus.ddr_chip_enable), 512'(1'b1));
    check("we_issue", 512'(bus.ddr_write_enable), 512'(exp_we));
    check("burst", 512'(bus.ddr_burst_mode), 512'((exp_g == 2) ? PTW_B : 1'b1));
    check("index", 512'(bus.ddr_index), 512'(bus.req_index[exp_g]));
    check("wdata", bus.ddr_write_data, bus.req_wdata[exp_g]);
    check("grant_id", 512'(grant_id), 512'(exp_g));
    check("busy_issue", 512'(busy), 512'(1'b1));
    check("ready_issue", 512'(bus.req_ready), 512'(3'b000));
    @(negedge clk);  // first WAIT cycle
    bus.ddr_operation_done = 1'b0;
    #1;
    check("ce_wait", 512'(bus.ddr_chip_enable), 512'(1'b0));
    check("busy_wait", 512'(busy), 512'(1'b1));
    repeat (lat - 1) @(negedge clk);
    check("no_early_done", 512'(bus.resp_done), 512'(3'b000));
    bus.ddr_operation_done = 1'b1;
    bus.ddr_read_data      = data;
    @(negedge clk);
    bus.ddr_operation_done = 1'b0;
    bus.ddr_read_data      = ~data;
    #1;
    check("done_lat", 512'(bus.resp_done), 512'(exp_oh));
    check("resp_err", 512'(bus.resp_err), 512'(1'b0));
    check("busy_done", 512'(busy), 512'(1'b0));
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  logic [511:0] d;

  initial begin
    rst                    = 1'b1;
    bus.req_valid          = 3'b000;
    bus.req_write          = 3'b000;
    bus.req_index[0]       = 64'h0000_0000_0000_1000;
    bus.req_index[1]       = 64'h0000_0000_0000_0040;
    bus.req_index[2]       = 64'h0000_0002_0000_0008;
    for (int i = 0; i < 3; i++) make_data(bus.req_wdata[i]);
    bus.ddr_read_data      = '0;
    bus.ddr_operation_done = 1'b0;
    bus.ddr_ready          = 1'b1;
    do_reset();

    // Reset state
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_grant_id", 512'(grant_id), 512'(2'd0));
    check("rst_ready", 512'(bus.req_ready), 512'(3'b000));
    check("rst_done", 512'(bus.resp_done), 512'(3'b000));
    check("rst_rdata", bus.resp_rdata, 512'(0));
    check("rst_err", 512'(bus.resp_err), 512'(1'b0));
    check("rst_ce", 512'(bus.ddr_chip_enable), 512'(1'b0));
    check("rst_we", 512'(bus.ddr_write_enable), 512'(1'b0));
    check("rst_burst", 512'(bus.ddr_burst_mode), 512'(1'b0));
    check("rst_index", 512'(bus.ddr_index), 512'(0));

    // Single dcache read, done 5 cycles after chip_enable
    d = {64{8'hA5}};
    run_txn(3'b010, 3'b000, 1'b0, 1, 5, d);

    // Contention from reset: 0,1,2 then back to 0
    do_reset();
    make_data(d); run_txn(3'b111, 3'b110, 1'b1, 0, 3, d);
    make_data(d); run_txn(3'b111, 3'b110, 1'b1, 1, 2, d);
    make_data(d); run_txn(3'b111, 3'b110, 1'b1, 2, 4, d);
    make_data(d); run_txn(3'b111, 3'b110, 1'b0, 0, 2, d);

    // Icache write attempt is forced to a read
    make_data(d); run_txn(3'b001, 3'b001, 1'b0, 0, 3, d);

    // DDR not ready for 10 cycles
    bus.ddr_ready = 1'b0;
    bus.req_valid = 3'b100;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("notready_ready", 512'(bus.req_ready), 512'(3'b000));
      check("notready_busy", 512'(busy), 512'(1'b0));
      @(negedge clk);
    end
    bus.ddr_ready = 1'b1;
    make_data(d); run_txn(3'b100, 3'b000, 1'b0, 2, 6, d);

    // Reset while in WAIT, then a stray done
    bus.req_valid = 3'b010;
    bus.req_write = 3'b000;
    #1;
    check("abandon_grant", 512'(bus.req_ready), 512'(3'b010));
    $display("txn: valid=010 granted then abandoned by reset");
    @(negedge clk);
    bus.req_valid = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ddr_operation_done = 1'b1;
    bus.ddr_read_data      = {16{32'hBAD0BAD0}};
    @(negedge clk);
    bus.ddr_operation_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("abandon_done", 512'(bus.resp_done), 512'(3'b000));
      check("abandon_busy", 512'(busy), 512'(1'b0));
      @(negedge clk);
    end
    make_data(d); run_txn(3'b111, 3'b000, 1'b0, 0, 3, d);

`ifdef DDR_REQ_SCHED_TIMEOUT_EN
    begin
      int   cyc;
      exp_t it;
      bus.req_valid = 3'b001;
      #1;
      check("to_grant", 512'(bus.req_ready), 512'(3'b001));
      it.id = 0; it.rd = 1'b1; it.data = '0; it.err = 1'b1;
      sb.push_back(it);
      $display("txn: valid=001 without done response");
      cyc = 0;
      while (bus.resp_done == 3'b000 && cyc < 100) begin
        @(negedge clk);
        bus.req_valid = 3'b000;
        #1;
        cyc++;
      end
      check("to_latency", 512'(cyc), 512'(18));
      check("to_err", 512'(bus.resp_err), 512'(1'b1));
      check("to_rdata", bus.resp_rdata, 512'(0));
      check("to_busy", 512'(busy), 512'(1'b0));
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 512'(sb.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_req_sched.md
DDR_REQ_SCHED -- requirements
Module: ddr_req_sched

Interface
- REQ-001 Parameter: TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit in cycles (used only with DDR_REQ_SCHED_TIMEOUT_EN).
- REQ-002 Parameter: PTW_BURST, 0, value driven on ddr_burst_mode for requester 2.
- REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
- REQ-004 clock  in  1  sole clock, all state on rising edge.
- REQ-005 reset  in  1  synchronous active-high reset.
- REQ-006 req_valid  in  3  per-requester request; bit 0 icache, bit 1 dcache, bit 2 ptw.
- REQ-007 req_ready  out  3  one-hot grant acknowledge.
- REQ-008 req_index  in  3x64  per-requester DDR index.
- REQ-009 req_write  in  3  per-requester write flag; bit 0 is ignored and forced to read.
- REQ-010 req_wdata  in  3x512  per-requester write line.
- REQ-011 resp_done  out  3  one-hot completion pulse.
- REQ-012 resp_rdata  out  512  read line, shared, valid with resp_done.
- REQ-013 resp_err  out  1  timeout flag, valid with resp_done.
- REQ-014 ddr_chip_enable / ddr_write_enable / ddr_burst_mode  out  1 each  DDR command strobes.
- REQ-015 ddr_index  out  64; ddr_write_data  out  512.
- REQ-016 ddr_read_data  in  512; ddr_operation_done  in  1; ddr_ready  in  1.
- REQ-017 busy  out  1  high in any state except IDLE; grant_id  out  2  id of the current or last grant.

Function
- REQ-018 FSM states SHALL be IDLE, ISSUE and WAIT.
- REQ-019 IDLE to ISSUE SHALL occur when any req_valid is set and ddr_ready=1; otherwise the FSM SHALL stay in IDLE.
- REQ-020 Arbitration SHALL be round-robin: search order is ptr+1, ptr+2, ptr (mod 3), ptr is the last granted id, and ptr updates on each grant.
- REQ-021 req_ready[g] SHALL be combinational, high only in IDLE in the grant cycle; index, write and wdata of g SHALL be latched in that cycle.
- REQ-022 ISSUE SHALL assert ddr_chip_enable for exactly one cycle with the latched index, write and wdata, then go to WAIT.
- REQ-023 ddr_burst_mode SHALL be 1 for requesters 0 and 1 and PTW_BURST for requester 2.
- REQ-024 WAIT SHALL register ddr_read_data and return to IDLE when ddr_operation_done=1; resp_done[g] SHALL pulse one cycle later, when the FSM is already in IDLE.
- REQ-025 Latency: grant at T, chip_enable at T+1, resp_done at D+1, where D is the ddr_operation_done cycle; a new grant MAY coincide with the resp_done cycle.
- REQ-026 ddr_operation_done SHALL be ignored in IDLE and ISSUE.
- REQ-027 Deassertion of req_valid after grant SHALL NOT cancel the operation.
- REQ-028 Write operations SHALL complete with resp_done; resp_rdata is don't-care for writes.
- REQ-029 DDR command outputs SHALL be 0 outside ISSUE, except ddr_index, ddr_write_data and ddr_burst_mode, which hold their latched values.

Reset
- REQ-030 On reset SHALL set: FSM to IDLE, ptr=2 (requester 0 is favoured first), all outputs 0, resp_rdata 0 and watchdog 0.
- REQ-031 Reset mid-WAIT SHALL abandon the operation; a later ddr_operation_done SHALL be ignored per REQ-026.

Configuration
- REQ-032 Macro DDR_REQ_SCHED_TIMEOUT_EN defined: a watchdog counts cycles in WAIT; on reaching TIMEOUT_CYCLES without ddr_operation_done, the block SHALL pulse resp_done[g] with resp_err=1 and resp_rdata=0, then return to IDLE.
- REQ-033 Macro undefined: no counter, resp_err tied 0, WAIT lasts indefinitely.

Verification
- REQ-034 Single read: req_valid=3'b010 with index 0x40, ddr_ready=1, done 5 cycles after chip_enable with data 0xA5.. -> req_ready=010 at T, chip_enable at T+1 only, resp_done=010 at D+1 with resp_rdata=0xA5.., resp_err=0.
- REQ-035 Contention: req_valid=3'b111 held for 3 transactions after reset -> grant order 0,1,2; a 4th grant goes to 0.
- REQ-036 Icache write attempt: req_valid=001, req_write=001 -> ddr_write_enable=0, ddr_burst_mode=1.
- REQ-037 DDR not ready: req_valid=100, ddr_ready=0 for 10 cycles, then 1 -> no req_ready during the 10 cycles; grant in the first ready cycle with burst_mode=PTW_BURST.
- REQ-038 Reset in WAIT, then a stray ddr_operation_done -> no resp_done, busy=0, next grant goes to requester 0.
- REQ-039 With DDR_REQ_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done response -> resp_done with resp_err=1 after 16 WAIT cycles, FSM returns to IDLE.
